// File: rtl/emc_wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: result entry layout and source ids.
package vi_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int NSRC    = 3;

  // One completed result; 102 bits, data in the top bits, pc in the bottom.
  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [RADDR_W-1:0] addr;
    logic               wr_en;
    logic [XLEN-1:0]    instr;
    logic [XLEN-1:0]    pc;
  } emc_entry_t;

  // Source ids double as priority rank: lower value = older instruction.
  typedef enum logic [1:0] {
    SRC_MULT  = 2'd0,
    SRC_CACHE = 2'd1,
    SRC_ALU   = 2'd2
  } src_e;

endpackage

// File: rtl/emc_queue.sv
// Ordered circular buffer holding results that lost a write-back collision.
// Accepts up to three pushes (index order) and one pop per cycle.
module emc_queue
  import vi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic [NSRC-1:0]        push_vld_i,
  input  emc_entry_t [NSRC-1:0]  push_ent_i,
  input  logic                   pop_i,
  output emc_entry_t             head_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  emc_entry_t        mem_q [DEPTH];
  emc_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  // Pop frees a slot before this cycle's pushes are placed; pushes beyond the
  // remaining space are dropped from the highest index (lowest priority) down.
  always_comb begin
    int               free;
    int               n;
    logic             pop;
    logic             drop;
    logic [PTR_W-1:0] wr_idx;
    mem_d      = mem_q;
    pop        = pop_i && (count_q != '0);
    free       = DEPTH - int'(count_q) + int'(pop);
    n          = 0;
    drop       = 1'b0;
    wr_idx     = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (push_vld_i[i]) begin
        if (n < free) begin
          wr_idx        = PTR_W'((int'(tail_q) + n) % DEPTH);
          mem_d[wr_idx] = push_ent_i[i];
          n             = n + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    head_d     = pop ? PTR_W'((int'(head_q) + 1) % DEPTH) : head_q;
    tail_d     = PTR_W'((int'(tail_q) + n) % DEPTH);
    count_d    = CNT_W'(int'(count_q) - int'(pop) + n);
    overflow_d = overflow_q | drop;
  end

  // Queue state register; reset discards all held entries.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head_o     = mem_q[head_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/emc_wb_arbiter.sv
// Write-back arbiter: merges mult5, cache and ALU results into one emc_*
// stream, one result per cycle, queueing collision losers in age order.
// Results are consumed unconditionally by exe_write_latch (no ready).
module emc_wb_arbiter
  import vi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rsn_i,
  input  logic               alu_valid_i,
  input  logic [31:0]        alu_data_i,
  input  logic [4:0]         alu_addr_i,
  input  logic               alu_wr_en_i,
  input  logic [31:0]        alu_instr_i,
  input  logic [31:0]        alu_pc_i,
  input  logic               mult_valid_i,
  input  logic [31:0]        mult_data_i,
  input  logic [4:0]         mult_addr_i,
  input  logic               mult_wr_en_i,
  input  logic [31:0]        mult_instr_i,
  input  logic [31:0]        mult_pc_i,
  input  logic               cache_valid_i,
  input  logic [31:0]        cache_data_i,
  input  logic [4:0]         cache_addr_i,
  input  logic               cache_wr_en_i,
  input  logic [31:0]        cache_instr_i,
  input  logic [31:0]        cache_pc_i,
  output logic               emc_valid_o,
  output logic [31:0]        emc_int_data_out_o,
  output logic [4:0]         emc_write_addr_o,
  output logic               emc_int_write_enable_o,
  output logic [31:0]        emc_instruction_o,
  output logic [31:0]        emc_pc_o,
  output logic               stall_core_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               overflow_o
);

  emc_entry_t [NSRC-1:0] in_ent;
  logic       [NSRC-1:0] in_vld;
  logic       [NSRC-1:0] push_vld;
  emc_entry_t            head;
  emc_entry_t            sel_ent;
  logic                  sel_vld;
  logic                  q_empty;
  logic [CNT_W-1:0]      count;
  src_e                  sel_src;

  // Inputs gathered in priority order: index 0 is the oldest (mult).
  always_comb begin
    in_ent[SRC_MULT]  = '{mult_data_i, mult_addr_i, mult_wr_en_i, mult_instr_i, mult_pc_i};
    in_ent[SRC_CACHE] = '{cache_data_i, cache_addr_i, cache_wr_en_i, cache_instr_i, cache_pc_i};
    in_ent[SRC_ALU]   = '{alu_data_i, alu_addr_i, alu_wr_en_i, alu_instr_i, alu_pc_i};
    in_vld            = {alu_valid_i, cache_valid_i, mult_valid_i};
  end

  assign q_empty = (count == '0);

  // Queued results are older than anything arriving, so the head always wins;
  // otherwise the oldest valid input bypasses and the rest are queued.
  always_comb begin
    sel_src  = SRC_MULT;
    sel_vld  = 1'b0;
    sel_ent  = '0;
    push_vld = in_vld;
    if (!q_empty) begin
      sel_vld = 1'b1;
      sel_ent = head;
    end else if (in_vld != '0) begin
      if (in_vld[SRC_MULT])       sel_src = SRC_MULT;
      else if (in_vld[SRC_CACHE]) sel_src = SRC_CACHE;
      else                        sel_src = SRC_ALU;
      sel_vld  = 1'b1;
      sel_ent  = in_ent[sel_src];
      push_vld = in_vld & ~(NSRC'(1) << sel_src);
    end
  end

  emc_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .push_vld_i (push_vld),
    .push_ent_i (in_ent),
    .pop_i      (!q_empty),
    .head_o     (head),
    .count_o    (count),
    .overflow_o (overflow_o)
  );

  // Outputs are forced low while reset is held, even if inputs are valid.
  always_comb begin
    emc_valid_o            = sel_vld & rsn_i;
    emc_int_data_out_o     = emc_valid_o ? sel_ent.data  : '0;
    emc_write_addr_o       = emc_valid_o ? sel_ent.addr  : '0;
    emc_int_write_enable_o = emc_valid_o & sel_ent.wr_en;
    emc_instruction_o      = emc_valid_o ? sel_ent.instr : '0;
    emc_pc_o               = emc_valid_o ? sel_ent.pc    : '0;
    stall_core_o           = rsn_i & ((DEPTH - int'(count)) < 3);
  end

  assign count_o = count;

endmodule

// File: tb/tb_emc_wb_arbiter.sv
// Directed + randomized bench for emc_wb_arbiter against a queue-based model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_emc_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk_i = 1'b0;
  logic rsn_i = 1'b0;

  // Source index 0 = mult, 1 = cache, 2 = alu. Entry = {data,addr,we,instr,pc}.
  logic         in_v [3];
  logic [101:0] in_e [3];

  logic              emc_valid_o, emc_int_write_enable_o, stall_core_o, overflow_o;
  logic [31:0]       emc_int_data_out_o, emc_instruction_o, emc_pc_o;
  logic [4:0]        emc_write_addr_o;
  logic [CNT_W-1:0]  count_o;

  logic [101:0] exp_q[$];
  bit           m_ovf;
  int           checks = 0;
  int           fails  = 0;

  always #5 clk_i = ~clk_i;

  emc_wb_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i                  (clk_i),
    .rsn_i                  (rsn_i),
    .alu_valid_i            (in_v[2]),
    .alu_data_i             (in_e[2][101:70]),
    .alu_addr_i             (in_e[2][69:65]),
    .alu_wr_en_i            (in_e[2][64]),
    .alu_instr_i            (in_e[2][63:32]),
    .alu_pc_i               (in_e[2][31:0]),
    .mult_valid_i           (in_v[0]),
    .mult_data_i            (in_e[0][101:70]),
    .mult_addr_i            (in_e[0][69:65]),
    .mult_wr_en_i           (in_e[0][64]),
    .mult_instr_i           (in_e[0][63:32]),
    .mult_pc_i              (in_e[0][31:0]),
    .cache_valid_i          (in_v[1]),
    .cache_data_i           (in_e[1][101:70]),
    .cache_addr_i           (in_e[1][69:65]),
    .cache_wr_en_i          (in_e[1][64]),
    .cache_instr_i          (in_e[1][63:32]),
    .cache_pc_i             (in_e[1][31:0]),
    .emc_valid_o            (emc_valid_o),
    .emc_int_data_out_o     (emc_int_data_out_o),
    .emc_write_addr_o       (emc_write_addr_o),
    .emc_int_write_enable_o (emc_int_write_enable_o),
    .emc_instruction_o      (emc_instruction_o),
    .emc_pc_o               (emc_pc_o),
    .stall_core_o           (stall_core_o),
    .count_o                (count_o),
    .overflow_o             (overflow_o)
  );

  function automatic logic [101:0] mk(input logic [31:0] d, input logic [4:0] a,
                                      input logic we, input logic [31:0] ins,
                                      input logic [31:0] pc);
    return {d, a, we, ins, pc};
  endfunction

  task automatic set_src(input int i, input logic v, input logic [101:0] e);
    in_v[i] = v;
    in_e[i] = e;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) set_src(i, 1'b0, '0);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs on negedge against the model, then advance model.
  task automatic tick(input string tag);
    logic [101:0] pend[$];
    logic [101:0] e;
    logic         ev;
    int           sz;
    @(negedge clk_i);
    pend.delete();
    for (int i = 0; i < 3; i++) if (in_v[i]) pend.push_back(in_e[i]);
    sz = exp_q.size();
    ev = 1'b0;
    e  = '0;
    if (rsn_i) begin
      if (sz > 0) begin ev = 1'b1; e = exp_q[0]; end
      else if (pend.size() > 0) begin ev = 1'b1; e = pend[0]; end
    end
    chk({tag, ".valid"}, 128'(emc_valid_o), 128'(ev));
    chk({tag, ".data"},  128'(emc_int_data_out_o), 128'(e[101:70]));
    chk({tag, ".addr"},  128'(emc_write_addr_o), 128'(e[69:65]));
    chk({tag, ".we"},    128'(emc_int_write_enable_o), 128'(e[64] & ev));
    chk({tag, ".instr"}, 128'(emc_instruction_o), 128'(e[63:32]));
    chk({tag, ".pc"},    128'(emc_pc_o), 128'(e[31:0]));
    chk({tag, ".count"}, 128'(count_o), 128'(sz));
    chk({tag, ".stall"}, 128'(stall_core_o), 128'(rsn_i && (DEPTH - sz) < 3));
    chk({tag, ".ovf"},   128'(overflow_o), 128'(m_ovf));
    @(posedge clk_i);
    if (rsn_i) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (pend.size() > 0) void'(pend.pop_front());
      foreach (pend[k]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pend[k]);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic assert_reset();
    rsn_i = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic rand_phase(input string tag, input int n, input bit obey_stall);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 3; i++)
        set_src(i, ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom));
      if (obey_stall && (DEPTH - exp_q.size()) < 3) idle();
      tick(tag);
    end
    idle();
  endtask

  initial begin
    idle();
    // Reset held with every source valid: outputs must stay quiet.
    assert_reset();
    set_src(0, 1'b1, mk(32'h1, 5'd1, 1'b1, 32'h11, 32'h10));
    set_src(1, 1'b1, mk(32'h2, 5'd2, 1'b1, 32'h22, 32'h14));
    set_src(2, 1'b1, mk(32'h3, 5'd3, 1'b1, 32'h33, 32'h18));
    tick("rst0");
    tick("rst1");
    rsn_i = 1'b1;
    tick("rel_mult");
    idle();
    tick("rel_drain0");
    tick("rel_drain1");
    tick("rel_idle");

    // Single ALU source with an empty queue.
    set_src(2, 1'b1, mk(32'h0000_1234, 5'd7, 1'b1, 32'hdead_0001, 32'h40));
    tick("single_alu");
    idle();
    tick("single_idle");

    // Three-way collision, then drain; stall tracks occupancy.
    set_src(0, 1'b1, mk(32'hA, 5'd1, 1'b1, 32'h1000, 32'h100));
    set_src(1, 1'b1, mk(32'hB, 5'd2, 1'b1, 32'h1001, 32'h104));
    set_src(2, 1'b1, mk(32'hC, 5'd3, 1'b1, 32'h1002, 32'h108));
    tick("coll_a");
    idle();
    tick("coll_b");
    tick("coll_c");
    tick("coll_idle");

    // Non-writing cache result still retires.
    set_src(1, 1'b1, mk(32'h55, 5'd9, 1'b0, 32'h2000, 32'h200));
    tick("nowrite");
    idle();

    rand_phase("rand", 300, 1'b1);
    repeat (4) tick("rand_drain");

    // Overflow: build count=3, then present three results despite the stall.
    for (int i = 0; i < 3; i++)
      set_src(i, 1'b1, mk(32'h100 + i, 5'(i), 1'b1, 32'h3000 + i, 32'h300 + 4 * i));
    tick("ovf_fill2");
    set_src(2, 1'b0, '0);
    tick("ovf_fill3");
    for (int i = 0; i < 3; i++)
      set_src(i, 1'b1, mk(32'h200 + i, 5'(8 + i), 1'b1, 32'h4000 + i, 32'h400 + 4 * i));
    tick("ovf_hit");
    idle();
    repeat (5) tick("ovf_drain");

    // Reset mid-operation discards queued entries.
    for (int i = 0; i < 3; i++)
      set_src(i, 1'b1, mk(32'h900 + i, 5'(20 + i), 1'b1, 32'h5000 + i, 32'h500 + 4 * i));
    tick("mid_fill");
    idle();
    assert_reset();
    tick("mid_rst");
    rsn_i = 1'b1;
    tick("mid_rel");

    rand_phase("rand_viol", 200, 1'b0);
    repeat (5) tick("final_drain");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
